// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit for the RV64I pipeline.
// One data-memory access per load/store over a req/ready handshake. Load data is
// formatted, and upstream is stalled until the access completes. Non-memory
// instructions pass through combinationally.
// Handshake: dmem_req is registered and held with we/addr/be/wdata stable. The
// access completes in the first cycle where dmem_req && dmem_ready. dmem_ready
// is ignored outside ACCESS.
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When defined, a misaligned
// H/W/D access traps (misalign_exc) instead of being aligned down.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [63:0] alu_result_in,
  input  logic [63:0] store_data_in,
  input  logic [2:0]  funct3_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [4:0]  rd_idx_in,
  input  logic        reg_write_in,
  input  logic [1:0]  mem_to_reg_in,
  input  logic [63:0] pc_plus4_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [7:0]  dmem_be,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [63:0] dmem_rdata,
  output logic        mem_stall,
  output logic        bus_err,
  output logic        misalign_exc,
  output logic [63:0] alu_result_out,
  output logic [63:0] mem_data_out,
  output logic [4:0]  rd_idx_out,
  output logic        reg_write_out,
  output logic [1:0]  mem_to_reg_out,
  output logic [63:0] pc_plus4_out,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_e;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d, pc_q, pc_d;
  logic [7:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic [1:0]  m2r_q, m2r_d;
  logic [CW-1:0] wait_q, wait_d;
  logic        bus_q, bus_d, mis_q, mis_d;

  logic [2:0]  off_in, lane_in;
  logic [7:0]  be_in;
  logic        mem_op_in;

  assign off_in    = alu_result_in[2:0];
  assign mem_op_in = valid_in & (mem_read_in | mem_write_in);

  // Raw doubleword -> register value: select the lane by offset, then extend.
  function automatic logic [63:0] fmt_load(input logic [2:0] f3, input logic [2:0] o,
                                           input logic [63:0] d);
    logic [63:0] sh;
    logic [63:0] r;
    sh = d;
    r  = d;
    case (f3[1:0])
      2'b00: begin
        sh = d >> {o, 3'b000};
        r  = f3[2] ? {56'd0, sh[7:0]} : {{56{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh = d >> {o[2:1], 4'b0000};
        r  = f3[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      end
      2'b10: begin
        sh = d >> {o[2], 5'b00000};
        r  = f3[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      end
      default: r = d;
    endcase
    return r;
  endfunction

  // Lane and byte enables of the incoming access; low offset bits below the size are dropped.
  always_comb begin
    lane_in = 3'd0;
    be_in   = 8'hFF;
    case (funct3_in[1:0])
      2'b00: begin lane_in = off_in;           be_in = 8'h01 << lane_in; end
      2'b01: begin lane_in = off_in & 3'b110;  be_in = 8'h03 << lane_in; end
      2'b10: begin lane_in = off_in & 3'b100;  be_in = 8'h0F << lane_in; end
      default: begin lane_in = 3'd0;           be_in = 8'hFF;            end
    endcase
    if (mem_read_in) be_in = 8'hFF;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_in;
  // Offset not a multiple of the access size.
  always_comb begin
    mis_in = 1'b0;
    case (funct3_in[1:0])
      2'b01:   mis_in = off_in[0];
      2'b10:   mis_in = |off_in[1:0];
      2'b11:   mis_in = |off_in;
      default: mis_in = 1'b0;
    endcase
  end
`endif

  // Next-state logic: latch the access in IDLE, wait for ready or timeout in ACCESS.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    m2r_d   = m2r_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    bus_d   = bus_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        bus_d = 1'b0;
        mis_d = 1'b0;
        if (mem_op_in) begin
          addr_d  = alu_result_in;
          be_d    = be_in;
          wdata_d = mem_write_in ? (store_data_in << {lane_in, 3'b000}) : 64'd0;
          f3_d    = funct3_in;
          rd_d    = rd_idx_in;
          rw_d    = reg_write_in;
          m2r_d   = mem_to_reg_in;
          pc_d    = pc_plus4_in;
          data_d  = 64'd0;
          wait_d  = '0;
          req_d   = 1'b1;
          we_d    = mem_write_in;
          state_d = S_ACCESS;
`ifdef MEM_MISALIGN_TRAP_EN
          if (mis_in) begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            mis_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_ACCESS: begin
        if (dmem_ready) begin
          data_d  = we_q ? 64'd0 : fmt_load(f3_q, addr_q[2:0], dmem_rdata);
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_DONE;
        end else if (wait_q == CW'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          bus_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DONE: begin
        bus_d   = 1'b0;
        mis_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched access registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 64'd0;
      be_q    <= 8'd0;
      wdata_q <= 64'd0;
      data_q  <= 64'd0;
      f3_q    <= 3'd0;
      rd_q    <= 5'd0;
      rw_q    <= 1'b0;
      m2r_q   <= 2'd0;
      pc_q    <= 64'd0;
      wait_q  <= '0;
      bus_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
      bus_q   <= bus_d;
      mis_q   <= mis_d;
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = {addr_q[63:3], 3'b000};
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;
  assign dbg_state_o = state_q;
  assign bus_err     = (state_q == S_DONE) & bus_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_exc = (state_q == S_DONE) & mis_q;
`else
  assign misalign_exc = 1'b0;
`endif

  // MEM/WB outputs: pass-through in IDLE, latched values otherwise, bubble while stalled.
  always_comb begin
    mem_stall      = 1'b0;
    alu_result_out = alu_result_in;
    mem_data_out   = 64'd0;
    rd_idx_out     = rd_idx_in;
    reg_write_out  = valid_in & reg_write_in;
    mem_to_reg_out = mem_to_reg_in;
    pc_plus4_out   = pc_plus4_in;
    if (state_q == S_IDLE) begin
      if (mem_op_in) begin
        mem_stall     = 1'b1;
        reg_write_out = 1'b0;
      end
    end else begin
      alu_result_out = addr_q;
      rd_idx_out     = rd_q;
      mem_to_reg_out = m2r_q;
      pc_plus4_out   = pc_q;
      if (state_q == S_ACCESS) begin
        mem_stall     = 1'b1;
        reg_write_out = 1'b0;
      end else begin
        mem_data_out  = data_q;
        reg_write_out = rw_q & ~bus_q & ~mis_q;
      end
    end
  end

endmodule
